// File: rtl/player_input_ctrl.sv
// player_input_ctrl
//   Front end for the player sprite block. It turns raw board buttons into a
//   clamped player column and a missile toggle vector. The block runs in the
//   31.5 MHz pixel clock domain.
//
//   Ports
//     clk            pixel clock
//     rst            asynchronous, active-low reset
//     btn_left       raw left button (asynchronous)
//     btn_right      raw right button (asynchronous)
//     btn_fire       raw fire button (asynchronous)
//     missle_en_xor  in-flight status per missile slot (1 = in flight)
//     btn_col        player sprite column
//     btn_missle_en  missile toggle vector; bits 7:3 are always 0
//     fire_pulse     one-cycle strobe when a shot is launched
//
//   Handshake: none. The outputs are plain registered levels. btn_missle_en
//   changes in the same cycle that fire_pulse is high. The player block
//   reports the result through missle_en_xor, and this block samples that
//   input combinationally.
//
//   Configuration macro: PLAYER_AUTOFIRE_EN
//     When defined, holding fire repeats a shot every FIRE_COOLDOWN+1 cycles
//     while a slot is free. When undefined, each press fires one shot.
module player_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 315000,
  parameter int MOVE_CYCLES     = 262144,
  parameter int STEP            = 2,
  parameter int COL_MIN         = 0,
  parameter int COL_MAX         = 624,
  parameter int COL_INIT        = 312,
  parameter int FIRE_COOLDOWN   = 3150000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_fire,
  input  logic [7:0]  missle_en_xor,
  output logic [11:0] btn_col,
  output logic [7:0]  btn_missle_en,
  output logic        fire_pulse
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int MV_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int CD_W = (FIRE_COOLDOWN > 1) ? $clog2(FIRE_COOLDOWN) : 1;

  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [MV_W-1:0] MV_LAST     = MV_W'(MOVE_CYCLES - 1);
  // COOLDOWN lasts CD_LOAD+1 cycles. Add the launch cycle in IDLE and the
  // shot-to-shot spacing comes to FIRE_COOLDOWN+1 cycles.
  localparam logic [CD_W-1:0] CD_LOAD     = CD_W'(FIRE_COOLDOWN - 1);
  localparam logic [11:0]     COL_MIN_C   = 12'(COL_MIN);
  localparam logic [11:0]     COL_MAX_C   = 12'(COL_MAX);
  localparam logic [11:0]     COL_INIT_C  = 12'(COL_INIT);
  localparam logic [11:0]     STEP_C      = 12'(STEP);
  // The limits are compared before the subtraction, so the column never
  // underflows past zero.
  localparam logic [11:0]     LEFT_LIMIT  = 12'(COL_MIN + STEP);
  localparam logic [11:0]     RIGHT_LIMIT = 12'(COL_MAX - STEP);

  // Button index: 0 = left, 1 = right, 2 = fire
  logic [2:0]      raw;
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      db_q;
  logic [DB_W-1:0] db_cnt_q [3];

  assign raw = {btn_fire, btn_right, btn_left};

  // Two-flop synchroniser, followed by a debounce counter for each button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Move tick: a free-running counter with a one-cycle tick at wrap.
  logic [MV_W-1:0] mv_cnt_q;
  logic            tick;

  assign tick = (mv_cnt_q == MV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mv_cnt_q <= '0;
    else      mv_cnt_q <= tick ? '0 : mv_cnt_q + MV_W'(1);
  end

  // Column update
  logic [11:0] col_q, col_d;

  always_comb begin
    col_d = col_q;
    if (tick) begin
      if (db_q[0] && !db_q[1]) begin
        col_d = (col_q < LEFT_LIMIT) ? COL_MIN_C : col_q - STEP_C;
      end else if (db_q[1] && !db_q[0]) begin
        col_d = (col_q > RIGHT_LIMIT) ? COL_MAX_C : col_q + STEP_C;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) col_q <= COL_INIT_C;
    else      col_q <= col_d;
  end

  // Slot select: the lowest free slot among 0..2
  logic       slot_free;
  logic [2:0] slot_mask;
  logic       unused_xor_hi;

  assign unused_xor_hi = ^missle_en_xor[7:3];

  always_comb begin
    slot_free = 1'b1;
    slot_mask = 3'b000;
    if (!missle_en_xor[0])      slot_mask = 3'b001;
    else if (!missle_en_xor[1]) slot_mask = 3'b010;
    else if (!missle_en_xor[2]) slot_mask = 3'b100;
    else                        slot_free = 1'b0;
  end

  // Fire FSM
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_COOLDOWN     = 2'd1,
    ST_WAIT_RELEASE = 2'd2
  } fire_state_t;

  fire_state_t     state_q;
  logic            fire_prev_q;
  logic [CD_W-1:0] cd_cnt_q;
  logic [2:0]      en_q;
  logic            pulse_q;
  logic            fire_rise;
  logic            fire_req;

  assign fire_rise = db_q[2] & ~fire_prev_q;
`ifdef PLAYER_AUTOFIRE_EN
  // A held button launches again. A rising edge implies that the button is held.
  assign fire_req = db_q[2] | fire_rise;
`else
  assign fire_req = fire_rise;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      fire_prev_q <= 1'b0;
      cd_cnt_q    <= '0;
      en_q        <= 3'b000;
      pulse_q     <= 1'b0;
    end else begin
      fire_prev_q <= db_q[2];
      pulse_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fire_req) begin
            if (slot_free) begin
              en_q     <= en_q ^ slot_mask;
              pulse_q  <= 1'b1;
              cd_cnt_q <= CD_LOAD;
              state_q  <= ST_COOLDOWN;
            end else begin
`ifndef PLAYER_AUTOFIRE_EN
              // All slots are busy, so the press is used up without a shot.
              state_q <= ST_WAIT_RELEASE;
`endif
            end
          end
        end
        ST_COOLDOWN: begin
          if (cd_cnt_q == '0) begin
`ifdef PLAYER_AUTOFIRE_EN
            state_q <= ST_IDLE;
`else
            state_q <= ST_WAIT_RELEASE;
`endif
          end else begin
            cd_cnt_q <= cd_cnt_q - CD_W'(1);
          end
        end
        ST_WAIT_RELEASE: begin
          if (!db_q[2]) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign btn_col       = col_q;
  assign btn_missle_en = {5'b00000, en_q};
  assign fire_pulse    = pulse_q;

endmodule

// File: doc/player_input_ctrl.md
Name: player_input_ctrl

Overview:
- Front end for the player sprite block: turns the raw board buttons (left, right, fire) into the player column and the missile toggle vector that the player block consumes.
- Synchronises and debounces each button, then moves the player column at a fixed rate with clamping.
- Arbitrates fire presses onto free missile slots using the in-flight status fed back from the player block.
- Sits between the board GPIO and the VGA player block, in the 31.5 MHz pixel clock domain.

Parameters:
- DEBOUNCE_CYCLES, 315000, stable cycles required before a button change is accepted (10 ms).
- MOVE_CYCLES, 262144, cycles between column steps while a direction is held.
- STEP, 2, pixels moved per step.
- COL_MIN, 0, leftmost legal column.
- COL_MAX, 624, rightmost legal column (640 - 16 sprite width).
- COL_INIT, 312, column after reset.
- FIRE_COOLDOWN, 3150000, minimum cycles between accepted shots (0.1 s).

Ports:
- clk  in  1  pixel clock, 31.5 MHz
- rst  in  1  asynchronous, active-low reset
- btn_left  in  1  raw left button, asynchronous to clk
- btn_right  in  1  raw right button, asynchronous to clk
- btn_fire  in  1  raw fire button, asynchronous to clk
- missle_en_xor  in  8  in-flight status from the player block; bit i=1 means missile i is in flight
- btn_col  out  12  player sprite column
- btn_missle_en  out  8  missile toggle vector to the player block
- fire_pulse  out  1  one-cycle strobe when a shot is launched

Behaviour:
- Reset (rst=0, asynchronous):
  - btn_col=COL_INIT, btn_missle_en=0, fire_pulse=0.
  - Debounced button states=0; all counters=0; fire FSM=IDLE.
  - The block runs on the first clk edge after rst deasserts.
- Synchronisers: each raw button passes through a 2-flop synchroniser.
- Debounce, per button:
  - The counter clears whenever the synchronised input equals the debounced state.
  - Otherwise it increments; on reaching DEBOUNCE_CYCLES-1 the debounced state takes the new value and the counter clears.
  - Latency from a stable input change to the debounced change is 2 + DEBOUNCE_CYCLES cycles.
- Move tick:
  - A free-running counter counts 0..MOVE_CYCLES-1 and produces a 1-cycle tick at wrap.
- Column update, on a tick only:
  - left only held: btn_col = max(btn_col - STEP, COL_MIN). Computed without 12-bit underflow, so btn_col < COL_MIN+STEP goes to COL_MIN.
  - right only held: btn_col = min(btn_col + STEP, COL_MAX).
  - both held or neither held: btn_col unchanged.
- Slot select: free slot = lowest i in {0,1,2} with missle_en_xor[i]=0. Bits 7:3 of btn_missle_en are always 0.
- Fire FSM states: IDLE, COOLDOWN, WAIT_RELEASE.
  - IDLE, on a debounced fire rising edge with a free slot i:
    - toggle btn_missle_en[i]; this flips the xor bit to 1 in the player block;
    - assert fire_pulse for 1 cycle;
    - load the cooldown counter; go to COOLDOWN.
  - IDLE, on a rising edge with no free slot: no toggle, no pulse; go to WAIT_RELEASE.
  - COOLDOWN: decrement the counter; at 0 go to WAIT_RELEASE. Presses during COOLDOWN are ignored.
  - WAIT_RELEASE: when debounced fire=0 go to IDLE.
- Fire-to-output latency: btn_missle_en and fire_pulse update on the cycle after the debounced rising edge is detected.
- Status input timing: missle_en_xor is sampled combinationally in IDLE. A slot freed on the same cycle as a press counts as free.
- Move vs fire: column moves and fire are independent. A shot and a step in the same cycle are both applied.
- Reset mid-operation: everything returns to reset values. In-flight missiles in the player block may see a phase flip; that is acceptable.

Optional Feature:
- Macro: PLAYER_AUTOFIRE_EN.
- Defined: COOLDOWN exits to IDLE instead of WAIT_RELEASE. In IDLE a held fire, not only a rising edge, launches when a slot is free, so holding fire repeats every FIRE_COOLDOWN+1 cycles.
- Undefined: the behaviour above; one shot per press.

Test Plan:
- All test cases use DEBOUNCE_CYCLES=4, MOVE_CYCLES=8, FIRE_COOLDOWN=16.
- Reset: rst=0 mid-run with left held -> btn_col=312, btn_missle_en=0, fire_pulse=0 immediately; no motion until after rst=1.
- Bounce: toggle btn_right every 2 cycles for 20 cycles, then hold 1 -> no column change during bouncing; after debounce, btn_col steps 312, 314, 316 on successive ticks.
- Clamp: start at btn_col=2 with left held -> 0 and stays 0, no wrap to 4094. Right held from 622 -> 624 and stays 624.
- Both held: left and right held for 100 cycles -> btn_col constant.
- Slot arbitration: missle_en_xor=0b001, press fire -> btn_missle_en[1] toggles, fire_pulse for 1 cycle. missle_en_xor=0b111, press -> no toggle, no pulse.
- Cooldown and release: hold fire 200 cycles -> exactly one pulse; release, then press again 5 cycles after the first shot -> ignored until cooldown expires. With PLAYER_AUTOFIRE_EN defined, holding 200 cycles gives a pulse every 17 cycles while slots are free.
